// File: rtl/calc_entry_pkg.sv
// Shared key codes, operation encodings and FSM states for the keypad front end.
package calc_entry_pkg;

   localparam logic [4:0] KEY_DOT = 5'd10;
   localparam logic [4:0] KEY_NEG = 5'd11;
   localparam logic [4:0] KEY_ADD = 5'd12;
   localparam logic [4:0] KEY_POW = 5'd16;
   localparam logic [4:0] KEY_EQ  = 5'd17;
   localparam logic [4:0] KEY_CLR = 5'd18;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_MUL = 3'd2,
      OP_DIV = 3'd3,
      OP_POW = 3'd4
   } op_e;

   typedef enum logic [2:0] {
      ST_ENTER0,
      ST_OPSEL,
      ST_ENTER1,
      ST_EVAL,
      ST_RESULT
   } state_e;

   function automatic logic is_digit_key(input logic [4:0] k);
      return k <= 5'd9;
   endfunction

   function automatic logic is_oper_key(input logic [4:0] k);
      return (k >= KEY_ADD) && (k <= KEY_POW);
   endfunction

   function automatic op_e key_to_op(input logic [4:0] k);
      logic [4:0] t;
      t = k - KEY_ADD;
      return op_e'(t[2:0]);
   endfunction

endpackage

// File: rtl/calc_entry_bcd_entry_reg.sv
// One BCD entry register: value, sign, fractional-digit count, dot flag and digit count.
// Within one cycle a clear or load is applied first, then at most one digit/dot/negate.
module bcd_entry_reg #(
   parameter int DIGIT_NUM = 8,
   parameter int DP_W      = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr_i,
   input  logic                   load_i,
   input  logic [DIGIT_NUM*4-1:0] load_val_i,
   input  logic                   load_sign_i,
   input  logic [DP_W-1:0]        load_dp_i,
   input  logic                   digit_i,
   input  logic [3:0]             digit_val_i,
   input  logic                   dot_i,
   input  logic                   neg_i,
   output logic [DIGIT_NUM*4-1:0] val_o,
   output logic                   sign_o,
   output logic [DP_W-1:0]        dp_o
);

   localparam int VAL_W = DIGIT_NUM * 4;
   localparam int CNT_W = $clog2(DIGIT_NUM + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIGIT_NUM);
   localparam logic [DP_W-1:0]  DP_MAX   = '1;

   logic [VAL_W-1:0] val_q, val_d;
   logic             sign_q, sign_d;
   logic [DP_W-1:0]  dp_q, dp_d;
   logic             dot_q, dot_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next-state: clear/load base, then the entry edit on top of it
   always_comb begin
      val_d  = val_q;
      sign_d = sign_q;
      dp_d   = dp_q;
      dot_d  = dot_q;
      cnt_d  = cnt_q;
      if (clr_i) begin
         val_d  = '0;
         sign_d = 1'b0;
         dp_d   = '0;
         dot_d  = 1'b0;
         cnt_d  = '0;
      end
      if (load_i) begin
         // A loaded result counts as full so it is never extended digit-wise
         val_d  = load_val_i;
         sign_d = load_sign_i;
         dp_d   = load_dp_i;
         dot_d  = |load_dp_i;
         cnt_d  = CNT_FULL;
      end
      if (digit_i) begin
         if ((cnt_d == CNT_FULL) || (dot_d && (dp_d == DP_MAX))) begin
            val_d = val_d;
         end else if ((val_d == '0) && !dot_d) begin
            val_d = VAL_W'(digit_val_i);
            cnt_d = (digit_val_i != 4'd0) ? CNT_W'(1) : '0;
         end else begin
            val_d = {val_d[VAL_W-5:0], digit_val_i};
            cnt_d = cnt_d + CNT_W'(1);
            if (dot_d) dp_d = dp_d + DP_W'(1);
         end
      end
      if (dot_i) dot_d = 1'b1;
      if (neg_i) sign_d = ~sign_d;
   end

   // Entry state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         val_q  <= '0;
         sign_q <= 1'b0;
         dp_q   <= '0;
         dot_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         val_q  <= val_d;
         sign_q <= sign_d;
         dp_q   <= dp_d;
         dot_q  <= dot_d;
         cnt_q  <= cnt_d;
      end
   end

   assign val_o  = val_q;
   assign sign_o = sign_q;
   assign dp_o   = dp_q;

endmodule

// File: rtl/calc_entry.sv
// Keypad entry front end: builds two BCD operands and an operation, captures the alu result.
module calc_entry
   import calc_entry_pkg::*;
#(
   parameter int DIGIT_NUM = 8,
   parameter int DP_W      = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   key_valid,
   input  logic [4:0]             key_code,
   output logic [DIGIT_NUM*4-1:0] operand0,
   output logic                   operand0_sign,
   output logic [DP_W-1:0]        operand0_dp,
   output logic [DIGIT_NUM*4-1:0] operand1,
   output logic                   operand1_sign,
   output logic [DP_W-1:0]        operand1_dp,
   output logic [2:0]             operation,
   input  logic [DIGIT_NUM*4-1:0] result,
   input  logic                   result_sign,
   input  logic [DP_W-1:0]        result_dp,
   output logic [DIGIT_NUM*4-1:0] disp_bcd,
   output logic                   disp_sign,
   output logic [DP_W-1:0]        disp_dp,
   output logic                   calc_done,
   output logic                   busy
);

   state_e state_q;
   op_e    op_q, pend_op_q;
   logic   chain_q, done_q;

   logic is_dig, is_dot, is_neg, is_opr, is_eq, is_clr;
   logic op0_clr, op0_load, op0_dig, op0_dot, op0_neg;
   logic op1_clr, op1_dig, op1_dot, op1_neg;

   assign is_dig = key_valid && is_digit_key(key_code);
   assign is_dot = key_valid && (key_code == KEY_DOT);
   assign is_neg = key_valid && (key_code == KEY_NEG);
   assign is_opr = key_valid && is_oper_key(key_code);
   assign is_eq  = key_valid && (key_code == KEY_EQ);
   assign is_clr = key_valid && (key_code == KEY_CLR);

   // Route the current key to the operand registers; op1 is cleared whenever OPSEL is entered
   always_comb begin
      op0_clr  = 1'b0;
      op0_load = 1'b0;
      op0_dig  = 1'b0;
      op0_dot  = 1'b0;
      op0_neg  = 1'b0;
      op1_clr  = 1'b0;
      op1_dig  = 1'b0;
      op1_dot  = 1'b0;
      op1_neg  = 1'b0;
      if (is_clr) begin
         op0_clr = 1'b1;
         op1_clr = 1'b1;
      end else begin
         unique case (state_q)
            ST_ENTER0: begin
               op0_dig = is_dig;
               op0_dot = is_dot;
               op0_neg = is_neg;
               op1_clr = is_opr;
            end
            ST_OPSEL: begin
               op1_clr = is_dig || is_dot || is_neg;
               op1_dig = is_dig;
               op1_dot = is_dot;
               op1_neg = is_neg;
            end
            ST_ENTER1: begin
               op1_dig = is_dig;
               op1_dot = is_dot;
               op1_neg = is_neg;
            end
            ST_EVAL: begin
               op0_load = 1'b1;
               op1_clr  = chain_q;
            end
            ST_RESULT: begin
               op0_clr = is_dig || is_dot;
               op0_dig = is_dig;
               op0_dot = is_dot;
               op0_neg = is_neg;
               op1_clr = is_dig || is_dot || is_opr;
            end
            default: ;
         endcase
      end
   end

   // Main FSM with registered operation, chain bookkeeping and done pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_ENTER0;
         op_q      <= OP_ADD;
         pend_op_q <= OP_ADD;
         chain_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (is_clr) begin
            state_q   <= ST_ENTER0;
            op_q      <= OP_ADD;
            pend_op_q <= OP_ADD;
            chain_q   <= 1'b0;
         end else begin
            unique case (state_q)
               ST_ENTER0: begin
                  if (is_opr) begin
                     op_q    <= key_to_op(key_code);
                     state_q <= ST_OPSEL;
                  end
               end
               ST_OPSEL: begin
                  if (is_opr) op_q <= key_to_op(key_code);
                  else if (is_dig || is_dot || is_neg) state_q <= ST_ENTER1;
               end
               ST_ENTER1: begin
                  if (is_opr) begin
                     pend_op_q <= key_to_op(key_code);
                     chain_q   <= 1'b1;
                     state_q   <= ST_EVAL;
                  end else if (is_eq) begin
                     chain_q <= 1'b0;
                     state_q <= ST_EVAL;
                  end
               end
               ST_EVAL: begin
                  done_q  <= 1'b1;
                  chain_q <= 1'b0;
                  if (chain_q) begin
                     op_q    <= pend_op_q;
                     state_q <= ST_OPSEL;
                  end else begin
                     state_q <= ST_RESULT;
                  end
               end
               ST_RESULT: begin
                  if (is_dig || is_dot) begin
                     op_q    <= OP_ADD;
                     state_q <= ST_ENTER0;
                  end else if (is_opr) begin
                     op_q    <= key_to_op(key_code);
                     state_q <= ST_OPSEL;
                  end
               end
               default: state_q <= ST_ENTER0;
            endcase
         end
      end
   end

   bcd_entry_reg #(.DIGIT_NUM(DIGIT_NUM), .DP_W(DP_W)) u_op0 (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (op0_clr),
      .load_i     (op0_load),
      .load_val_i (result),
      .load_sign_i(result_sign),
      .load_dp_i  (result_dp),
      .digit_i    (op0_dig),
      .digit_val_i(key_code[3:0]),
      .dot_i      (op0_dot),
      .neg_i      (op0_neg),
      .val_o      (operand0),
      .sign_o     (operand0_sign),
      .dp_o       (operand0_dp)
   );

   bcd_entry_reg #(.DIGIT_NUM(DIGIT_NUM), .DP_W(DP_W)) u_op1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (op1_clr),
      .load_i     (1'b0),
      .load_val_i ('0),
      .load_sign_i(1'b0),
      .load_dp_i  ('0),
      .digit_i    (op1_dig),
      .digit_val_i(key_code[3:0]),
      .dot_i      (op1_dot),
      .neg_i      (op1_neg),
      .val_o      (operand1),
      .sign_o     (operand1_sign),
      .dp_o       (operand1_dp)
   );

   // Display follows op1 while it is being entered or evaluated, op0 otherwise
   always_comb begin
      if ((state_q == ST_ENTER1) || (state_q == ST_EVAL)) begin
         disp_bcd  = operand1;
         disp_sign = operand1_sign;
         disp_dp   = operand1_dp;
      end else begin
         disp_bcd  = operand0;
         disp_sign = operand0_sign;
         disp_dp   = operand0_dp;
      end
   end

   assign operation = op_q;
   assign calc_done = done_q;
   assign busy      = (state_q == ST_EVAL);

endmodule
